fill_sequencer: RTL and testbench

//  Sequences the polygon fill engine through one complete fill command, row by row.

---
 rtl/gpu_fill_pkg.sv | 18 +
 rtl/fill_sequencer.sv | 148 ++++++++++++++
 tb/tb_fill_sequencer.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpu_fill_pkg.sv
// Shared types and defaults for the polygon fill sequencer.
package gpu_fill_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MATH = 3'd1,
    REQ  = 3'd2,
    READ = 3'd3,
    WAIT = 3'd4,
    FILL = 3'd5,
    GAP  = 3'd6,
    DONE = 3'd7
  } fill_seq_state_t;

  localparam int FILL_ROWS   = 64;
  localparam int FILL_RD_LAT = 2;

endpackage

// File: rtl/fill_sequencer.sv
// Steps the fill engine through one command: min-corner math, then per row
// SRAM arbitration, read, read-latency wait and fill/write-back.
module fill_sequencer
  import gpu_fill_pkg::*;
#(
  parameter int ROWS   = FILL_ROWS,
  parameter int RD_LAT = FILL_RD_LAT,
  parameter int ROW_W  = $clog2(ROWS)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_layer,
  input  logic             abort,
  output logic             layer_num,
  output logic             math_start,
  input  logic             math_done,
  output logic             row_start,
  output logic             fill_start,
  input  logic             fill_done,
  output logic             sram_req,
  input  logic             sram_gnt,
  output logic [ROW_W-1:0] row_idx,
  output logic             busy,
  output logic             done
);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
  localparam logic [3:0]       LAT_LOAD = 4'(RD_LAT - 1);

  fill_seq_state_t  state_r;
  fill_seq_state_t  state_nxt_s;
  logic [ROW_W-1:0] row_idx_r;
  logic [ROW_W-1:0] row_idx_nxt_s;
  logic [3:0]       lat_cnt_r;
  logic [3:0]       lat_cnt_nxt_s;
  logic             layer_r;
  logic             layer_nxt_s;
  logic             cmd_ready_r;
  logic             busy_r;
  logic             math_start_r;
  logic             row_start_r;
  logic             fill_start_r;
  logic             sram_req_r;
  logic             done_r;

  // Next-state, row counter and latency counter; abort overrides every transition.
  always_comb begin
    state_nxt_s   = state_r;
    row_idx_nxt_s = row_idx_r;
    lat_cnt_nxt_s = lat_cnt_r;
    layer_nxt_s   = layer_r;
    if (abort) begin
      state_nxt_s   = IDLE;
      row_idx_nxt_s = '0;
      lat_cnt_nxt_s = 4'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (cmd_valid) begin
            layer_nxt_s   = cmd_layer;
            row_idx_nxt_s = '0;
            state_nxt_s   = MATH;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        MATH: begin
          if (math_done) state_nxt_s = REQ;
          else           state_nxt_s = MATH;
        end
        REQ: begin
          if (sram_gnt) state_nxt_s = READ;
          else          state_nxt_s = REQ;
        end
        READ: begin
          lat_cnt_nxt_s = LAT_LOAD;
          // a single-cycle read latency needs no WAIT cycle at all
          if (LAT_LOAD == 4'd0) state_nxt_s = FILL;
          else                  state_nxt_s = WAIT;
        end
        WAIT: begin
          lat_cnt_nxt_s = lat_cnt_r - 4'd1;
          if (lat_cnt_r <= 4'd1) state_nxt_s = FILL;
          else                   state_nxt_s = WAIT;
        end
        FILL: begin
          if (fill_done) begin
            if (row_idx_r == LAST_ROW) begin
              state_nxt_s = DONE;
            end else begin
              row_idx_nxt_s = row_idx_r + ROW_ONE;
              state_nxt_s   = GAP;
            end
          end else begin
            state_nxt_s = FILL;
          end
        end
        GAP:     state_nxt_s = REQ;
        DONE:    state_nxt_s = IDLE;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // State, counters and outputs, all registered from the next-state decode.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_r      <= IDLE;
      row_idx_r    <= '0;
      lat_cnt_r    <= 4'd0;
      layer_r      <= 1'b0;
      cmd_ready_r  <= 1'b1;
      busy_r       <= 1'b0;
      math_start_r <= 1'b0;
      row_start_r  <= 1'b0;
      fill_start_r <= 1'b0;
      sram_req_r   <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      row_idx_r    <= row_idx_nxt_s;
      lat_cnt_r    <= lat_cnt_nxt_s;
      layer_r      <= layer_nxt_s;
      cmd_ready_r  <= (state_nxt_s == IDLE);
      busy_r       <= (state_nxt_s != IDLE);
      math_start_r <= (state_nxt_s == MATH);
      row_start_r  <= (state_nxt_s == READ);
      fill_start_r <= (state_nxt_s == FILL);
      sram_req_r   <= (state_nxt_s == REQ)  || (state_nxt_s == READ) ||
                      (state_nxt_s == WAIT) || (state_nxt_s == FILL);
      done_r       <= (state_nxt_s == DONE);
    end
  end

  assign cmd_ready  = cmd_ready_r;
  assign busy       = busy_r;
  assign math_start = math_start_r;
  assign row_start  = row_start_r;
  assign fill_start = fill_start_r;
  assign sram_req   = sram_req_r;
  assign done       = done_r;
  assign row_idx    = row_idx_r;
  assign layer_num  = layer_r;

endmodule

// File: tb/tb_fill_sequencer.sv
// Directed bench for fill_sequencer: one instance at RD_LAT=2, one at RD_LAT=4,
// each driven by a small engine/arbiter responder.
module tb_fill_sequencer;

  logic       clk = 1'b0;
  logic       n_rst, cmd_layer, abort;
  logic       cmd_valid_a, math_done_a, fill_done_a, sram_gnt_a;
  logic       cmd_ready_a, layer_num_a, math_start_a, row_start_a, fill_start_a;
  logic       sram_req_a, busy_a, done_a;
  logic [5:0] row_idx_a;
  logic       cmd_valid_b, math_done_b, fill_done_b, sram_gnt_b;
  logic       cmd_ready_b, layer_num_b, math_start_b, row_start_b, fill_start_b;
  logic       sram_req_b, busy_b, done_b;
  logic [5:0] row_idx_b;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  int rs_cyc [2][64];
  int rs_count [2], lowcnt [2], last_rs [2], done_cnt [2], done_cyc [2];
  int excl_bad [2], row_seq_bad [2], low_bad [2], fs_lat_bad [2], layer_bad [2];
  int lat_exp [2];
  int exp_layer [2];
  logic fs_prev [2], fill_prev [2], granted [2];
  int stall_row, stall_left;

  always #5 clk = ~clk;

  fill_sequencer #(.ROWS(64), .RD_LAT(2), .ROW_W(6)) u_dut_a (
    .clk(clk), .n_rst(n_rst), .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a),
    .cmd_layer(cmd_layer), .abort(abort), .layer_num(layer_num_a),
    .math_start(math_start_a), .math_done(math_done_a), .row_start(row_start_a),
    .fill_start(fill_start_a), .fill_done(fill_done_a), .sram_req(sram_req_a),
    .sram_gnt(sram_gnt_a), .row_idx(row_idx_a), .busy(busy_a), .done(done_a)
  );

  fill_sequencer #(.ROWS(64), .RD_LAT(4), .ROW_W(6)) u_dut_b (
    .clk(clk), .n_rst(n_rst), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
    .cmd_layer(cmd_layer), .abort(abort), .layer_num(layer_num_b),
    .math_start(math_start_b), .math_done(math_done_b), .row_start(row_start_b),
    .fill_start(fill_start_b), .fill_done(fill_done_b), .sram_req(sram_req_b),
    .sram_gnt(sram_gnt_b), .row_idx(row_idx_b), .busy(busy_b), .done(done_b)
  );

  task automatic check_vec(input string tag, input int act, input int exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic clr(input int k);
    rs_count[k] = 0; lowcnt[k] = 0; last_rs[k] = 0; done_cnt[k] = 0; done_cyc[k] = 0;
    excl_bad[k] = 0; row_seq_bad[k] = 0; low_bad[k] = 0; fs_lat_bad[k] = 0;
    layer_bad[k] = 0; fs_prev[k] = 1'b0;
    for (int i = 0; i < 64; i++) rs_cyc[k][i] = 0;
  endtask

  task automatic mon(input int k, input logic ms, input logic rs, input logic fs,
                     input logic sr, input logic [5:0] ri, input logic ln,
                     input logic dn, input logic bz);
    if ((int'(ms) + int'(rs) + int'(fs)) > 1) excl_bad[k]++;
    if (rs) begin
      if (int'(ri) != (rs_count[k] % 64)) row_seq_bad[k]++;
      if ((rs_count[k] % 64) > 0 && lowcnt[k] != 1) low_bad[k]++;
      if (rs_count[k] < 64) rs_cyc[k][rs_count[k]] = cyc;
      rs_count[k]++;
      lowcnt[k] = 0;
      last_rs[k] = cyc;
    end
    if (fs && !fs_prev[k] && (cyc - last_rs[k]) != lat_exp[k]) fs_lat_bad[k]++;
    fs_prev[k] = fs;
    if (!sr && bz) lowcnt[k]++;
    if (dn) begin
      done_cnt[k]++;
      done_cyc[k] = cyc;
    end
    if (bz && int'(ln) != exp_layer[k]) layer_bad[k]++;
  endtask

  // engine answers math at once and fill_done on the second FILL cycle
  task automatic resp(input int k, input logic ms, input logic rs, input logic fs,
                      input logic sr, input logic [5:0] ri,
                      output logic md, output logic gnt, output logic fd);
    logic req;
    if (!sr) granted[k] = 1'b0;
    if (rs) granted[k] = 1'b1;
    req = sr && !granted[k] && !rs;
    md  = ms;
    if (k == 0 && req && int'(ri) == stall_row && stall_left > 0) begin
      gnt = 1'b0;
      stall_left--;
    end else begin
      gnt = req;
    end
    fd = fs && fill_prev[k];
    fill_prev[k] = fs;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    mon(0, math_start_a, row_start_a, fill_start_a, sram_req_a, row_idx_a, layer_num_a, done_a, busy_a);
    mon(1, math_start_b, row_start_b, fill_start_b, sram_req_b, row_idx_b, layer_num_b, done_b, busy_b);
    resp(0, math_start_a, row_start_a, fill_start_a, sram_req_a, row_idx_a, math_done_a, sram_gnt_a, fill_done_a);
    resp(1, math_start_b, row_start_b, fill_start_b, sram_req_b, row_idx_b, math_done_b, sram_gnt_b, fill_done_b);
  endtask

  task automatic wait_done(input int k, input int target, input int budget);
    int n = 0;
    while (done_cnt[k] < target && n < budget) begin
      cycle();
      n++;
    end
    check_vec("wait_done", done_cnt[k], target);
  endtask

  function automatic int outs_a();
    return int'({cmd_ready_a, busy_a, math_start_a, row_start_a, fill_start_a,
                 sram_req_a, done_a, layer_num_a});
  endfunction

  initial begin
    int t0;
    bit found;
    n_rst = 1'b0; cmd_layer = 1'b0; abort = 1'b0;
    cmd_valid_a = 1'b0; math_done_a = 1'b0; fill_done_a = 1'b0; sram_gnt_a = 1'b0;
    cmd_valid_b = 1'b0; math_done_b = 1'b0; fill_done_b = 1'b0; sram_gnt_b = 1'b0;
    lat_exp[0] = 2; lat_exp[1] = 4;
    exp_layer[0] = 0; exp_layer[1] = 0;
    stall_row = -1; stall_left = 0;
    for (int k = 0; k < 2; k++) begin
      fill_prev[k] = 1'b0; granted[k] = 1'b0;
      clr(k);
    end

    // reset state
    cycle(); cycle();
    check_vec("rst_outs", outs_a(), 8'b1000_0000);
    check_vec("rst_row", int'(row_idx_a), 0);
    n_rst = 1'b1;
    cycle();

    // 1: nominal, layer 1
    clr(0); exp_layer[0] = 1; cmd_layer = 1'b1; cmd_valid_a = 1'b1;
    cycle();
    cmd_valid_a = 1'b0; t0 = cyc;
    check_vec("t1_math", outs_a(), 8'b0110_0001);
    wait_done(0, 1, 1000);
    cycle();
    check_vec("t1_idle", int'({cmd_ready_a, busy_a}), 2);
    cycle(); cycle();
    check_vec("t1_done_cnt", done_cnt[0], 1);
    check_vec("t1_rows", rs_count[0], 64);
    check_vec("t1_row_seq", row_seq_bad[0], 0);
    check_vec("t1_first_rs", rs_cyc[0][0] - t0, 2);
    check_vec("t1_row_period", rs_cyc[0][1] - rs_cyc[0][0], 6);
    check_vec("t1_done_time", done_cyc[0] - rs_cyc[0][63], 4);
    check_vec("t1_layer", layer_bad[0], 0);
    check_vec("t1_excl", excl_bad[0], 0);
    check_vec("t1_fill_lat", fs_lat_bad[0], 0);
    check_vec("t1_req_gap", low_bad[0], 0);

    // 2: arbiter stall of 5 cycles on row 10
    clr(0); exp_layer[0] = 0; cmd_layer = 1'b0; stall_row = 10; stall_left = 5;
    cmd_valid_a = 1'b1;
    cycle();
    cmd_valid_a = 1'b0;
    wait_done(0, 1, 1000);
    cycle();
    check_vec("t2_stall_used", stall_left, 0);
    check_vec("t2_pre", rs_cyc[0][9] - rs_cyc[0][8], 6);
    check_vec("t2_stalled", rs_cyc[0][10] - rs_cyc[0][9], 11);
    check_vec("t2_post", rs_cyc[0][11] - rs_cyc[0][10], 6);
    check_vec("t2_req_held", low_bad[0], 0);
    check_vec("t2_excl", excl_bad[0], 0);
    check_vec("t2_layer", layer_bad[0], 0);
    stall_row = -1;

    // 3: RD_LAT=4 instance
    clr(1); exp_layer[1] = 1; cmd_layer = 1'b1; cmd_valid_b = 1'b1;
    cycle();
    cmd_valid_b = 1'b0;
    wait_done(1, 1, 2000);
    cycle();
    check_vec("t3_rows", rs_count[1], 64);
    check_vec("t3_fill_lat", fs_lat_bad[1], 0);
    check_vec("t3_req_gap", low_bad[1], 0);
    check_vec("t3_row_period", rs_cyc[1][1] - rs_cyc[1][0], 8);
    check_vec("t3_done_time", done_cyc[1] - rs_cyc[1][63], 6);
    check_vec("t3_excl", excl_bad[1], 0);
    check_vec("t3_idle", int'({cmd_ready_b, busy_b, sram_req_b}), 4);

    // 4: abort in FILL of row 30 together with fill_done
    clr(0); exp_layer[0] = 1; cmd_layer = 1'b1; cmd_valid_a = 1'b1;
    cycle();
    cmd_valid_a = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 1000 && !found; n++) begin
      cycle();
      if (fill_start_a && row_idx_a == 6'd30 && fill_done_a) found = 1'b1;
    end
    check_vec("t4_reached", int'(found), 1);
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    check_vec("t4_outs", outs_a() & 8'hFE, 8'b1000_0000);
    check_vec("t4_row", int'(row_idx_a), 0);
    cycle(); cycle(); cycle();
    check_vec("t4_no_done", done_cnt[0], 0);
    check_vec("t4_stay_idle", int'(busy_a), 0);

    // 5: reset while in WAIT of row 5
    clr(0); exp_layer[0] = 1; cmd_layer = 1'b1; cmd_valid_a = 1'b1;
    cycle();
    cmd_valid_a = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 1000 && !found; n++) begin
      cycle();
      if (row_start_a && row_idx_a == 6'd5) found = 1'b1;
    end
    check_vec("t5_reached", int'(found), 1);
    cycle();
    check_vec("t5_in_wait", outs_a(), 8'b0100_0101);
    n_rst = 1'b0;
    cycle();
    n_rst = 1'b1;
    check_vec("t5_rst_outs", outs_a(), 8'b1000_0000);
    check_vec("t5_rst_row", int'(row_idx_a), 0);
    clr(0); exp_layer[0] = 0; cmd_layer = 1'b0; cmd_valid_a = 1'b1;
    cycle();
    cmd_valid_a = 1'b0; t0 = cyc;
    check_vec("t5_restart", outs_a(), 8'b0110_0000);
    wait_done(0, 1, 1000);
    check_vec("t5_rows", rs_count[0], 64);
    check_vec("t5_first_rs", rs_cyc[0][0] - t0, 2);
    check_vec("t5_row_seq", row_seq_bad[0], 0);

    // 6: cmd_valid held across DONE
    cycle(); cycle();
    clr(0); exp_layer[0] = 1; cmd_layer = 1'b1; cmd_valid_a = 1'b1;
    cycle();
    wait_done(0, 1, 1000);
    t0 = done_cyc[0];
    cycle();
    cycle();
    check_vec("t6_reaccept", int'(math_start_a), 1);
    check_vec("t6_reaccept_time", cyc - t0, 2);
    wait_done(0, 2, 1000);
    cmd_valid_a = 1'b0;
    cycle(); cycle(); cycle();
    check_vec("t6_done_cnt", done_cnt[0], 2);
    check_vec("t6_rows", rs_count[0], 128);
    check_vec("t6_row_seq", row_seq_bad[0], 0);
    check_vec("t6_idle", int'(busy_a), 0);
    check_vec("t6_excl", excl_bad[0], 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
